// File: rtl/rr_arbiter8.sv
// Round-robin / fixed-priority arbiter for N requesters with hold-time limit.
// One grant at a time, registered outputs, one idle cycle between grants.
module rr_arbiter8 #(
  parameter int N        = 8,
  parameter int IDX_W    = 3,
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             rel,
  input  logic             prio_mode,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             valid,
  output logic             timeout
);

  localparam int HOLD_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [N-1:0]      gnt_q, gnt_d;
  logic [IDX_W-1:0]  gnt_idx_q, gnt_idx_d;
  logic              valid_q, valid_d;
  logic              timeout_q, timeout_d;

  logic              rr_found;
  logic [IDX_W-1:0]  rr_idx;
  logic [IDX_W-1:0]  fp_idx;
  logic [IDX_W-1:0]  win_idx;

  // Winner selection: rotating scan from ptr, or highest set bit.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = {IDX_W{1'b0}};
    fp_idx   = {IDX_W{1'b0}};
    for (int i = 0; i < N; i++) begin
      if (!rr_found && req[ptr_q + IDX_W'(i)]) begin
        rr_found = 1'b1;
        rr_idx   = ptr_q + IDX_W'(i);
      end else begin
        rr_found = rr_found;
      end
      if (req[i]) begin
        fp_idx = IDX_W'(i);
      end else begin
        fp_idx = fp_idx;
      end
    end
    if (prio_mode) begin
      win_idx = fp_idx;
    end else begin
      win_idx = rr_idx;
    end
  end

  // Next-state and output logic for the grant FSM.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    gnt_d      = gnt_q;
    gnt_idx_d  = gnt_idx_q;
    valid_d    = valid_q;
    timeout_d  = 1'b0;
    case (state_q)
      IDLE: begin
        gnt_d      = {N{1'b0}};
        gnt_idx_d  = {IDX_W{1'b0}};
        valid_d    = 1'b0;
        hold_cnt_d = {HOLD_W{1'b0}};
        if (|req) begin
          state_d          = BUSY;
          gnt_d[win_idx]   = 1'b1;
          gnt_idx_d        = win_idx;
          valid_d          = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        // A normal release outranks the hold limit when both hit together.
        if (rel || !req[gnt_idx_q] || (hold_cnt_q == HOLD_W'(MAX_HOLD - 1))) begin
          state_d    = IDLE;
          ptr_d      = gnt_idx_q + IDX_W'(1);
          hold_cnt_d = {HOLD_W{1'b0}};
          gnt_d      = {N{1'b0}};
          gnt_idx_d  = {IDX_W{1'b0}};
          valid_d    = 1'b0;
          if (rel || !req[gnt_idx_q]) begin
            timeout_d = 1'b0;
          end else begin
            timeout_d = 1'b1;
          end
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      default: begin
        state_d    = IDLE;
        ptr_d      = {IDX_W{1'b0}};
        hold_cnt_d = {HOLD_W{1'b0}};
        gnt_d      = {N{1'b0}};
        gnt_idx_d  = {IDX_W{1'b0}};
        valid_d    = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= {IDX_W{1'b0}};
      hold_cnt_q <= {HOLD_W{1'b0}};
      gnt_q      <= {N{1'b0}};
      gnt_idx_q  <= {IDX_W{1'b0}};
      valid_q    <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      gnt_q      <= gnt_d;
      gnt_idx_q  <= gnt_idx_d;
      valid_q    <= valid_d;
      timeout_q  <= timeout_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_idx = gnt_idx_q;
  assign valid   = valid_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Scoreboard bench for rr_arbiter8: stimulus queues expected grants, a
// negedge monitor checks each grant's index, length and ending timeout.
module tb_rr_arbiter8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic       rel;
  logic       prio_mode;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       valid;
  logic       timeout;

  typedef struct {
    int idx;
    int len;
    int to;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  rr_arbiter8 #(.N(8), .IDX_W(3), .MAX_HOLD(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .rel       (rel),
    .prio_mode (prio_mode),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .valid     (valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int idx, input int len, input int to);
    exp_t e;
    e.idx = idx;
    e.len = len;
    e.to  = to;
    exp_q.push_back(e);
  endtask

  // Monitor: pop on each new grant, check length and timeout when it ends.
  initial begin
    exp_t       cur;
    logic       prev_valid;
    int         run_len;
    logic [7:0] onehot;
    prev_valid = 1'b0;
    run_len    = 0;
    cur.idx = 0; cur.len = 0; cur.to = 0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (valid === 1'b1 && prev_valid === 1'b0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_grant", {29'd0, gnt_idx}, 32'hFFFF_FFFF);
        end else begin
          cur    = exp_q.pop_front();
          onehot = 8'd1 << cur.idx;
          chk("grant_idx", {29'd0, gnt_idx}, cur.idx);
          chk("grant_onehot", {24'd0, gnt}, {24'd0, onehot});
        end
        run_len = 1;
      end else if (valid === 1'b1) begin
        run_len++;
      end
      if (valid === 1'b0 && prev_valid === 1'b1) begin
        if (cur.len != 0) chk("grant_len", run_len, cur.len);
        chk("end_timeout", {31'd0, timeout}, cur.to);
        chk("idle_gnt", {24'd0, gnt}, 32'd0);
      end else begin
        chk("spurious_timeout", {31'd0, timeout}, 32'd0);
      end
      prev_valid = valid;
    end
  end

  initial begin
    rst = 1'b1; req = 8'hFF; rel = 1'b0; prio_mode = 1'b0;

    // 1. reset held two cycles with all requests high
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_gnt", {24'd0, gnt}, 32'd0);
      chk("rst_valid", {31'd0, valid}, 32'd0);
      chk("rst_timeout", {31'd0, timeout}, 32'd0);
      chk("rst_idx", {29'd0, gnt_idx}, 32'd0);
    end
    rst = 1'b0; req = 8'h00;
    tick();

    // 2. round robin 0..7,0 with one-cycle rel after each grant
    for (int i = 0; i < 9; i++) begin
      push(i % 8, 1, 0);
      req = 8'hFF; rel = 1'b0;
      tick();
      rel = 1'b1;
      tick();
      rel = 1'b0;
    end
    req = 8'h00;
    tick();

    // 3. fixed priority picks highest index twice
    prio_mode = 1'b1;
    for (int i = 0; i < 2; i++) begin
      push(6, 1, 0);
      req = 8'b0101_0101; rel = 1'b0;
      tick();
      rel = 1'b1;
      tick();
      rel = 1'b0;
    end
    req = 8'h00; prio_mode = 1'b0;
    tick();

    // 4. forced release after 16 cycles, one idle cycle, re-grant
    push(2, 16, 1);
    push(2, 1, 0);
    req = 8'h04;
    tick();
    for (int i = 0; i < 16; i++) tick();
    chk("to_drop_valid", {31'd0, valid}, 32'd0);
    chk("to_pulse", {31'd0, timeout}, 32'd1);
    tick();
    chk("to_regrant_valid", {31'd0, valid}, 32'd1);
    rel = 1'b1;
    tick();
    rel = 1'b0; req = 8'h00;
    tick();

    // 5. idx 7 with rel and hold limit together, then wrap to 0
    push(7, 16, 0);
    req = 8'h80;
    tick();
    for (int i = 0; i < 15; i++) tick();
    rel = 1'b1;
    tick();
    rel = 1'b0; req = 8'h81;
    push(0, 1, 0);
    tick();
    rel = 1'b1;
    tick();
    rel = 1'b0; req = 8'h00;
    tick();

    // 6. reset during a grant of idx 3 resets the pointer
    push(3, 1, 0);
    req = 8'h08;
    tick();
    req = 8'hFF; rst = 1'b1;
    tick();
    chk("mid_rst_valid", {31'd0, valid}, 32'd0);
    chk("mid_rst_timeout", {31'd0, timeout}, 32'd0);
    rst = 1'b0;
    push(0, 1, 0);
    tick();
    rel = 1'b1;
    tick();
    rel = 1'b0;

    // 7. owner drops its request; a non-owner request waits for idle
    push(4, 1, 0);
    req = 8'h10;
    tick();
    req = 8'h01;
    tick();
    push(0, 1, 0);
    tick();
    req = 8'h00;
    tick();
    for (int i = 0; i < 4; i++) tick();

    chk("queue_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
